// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: IF/LS arbiter and response sequencer for the single-port
// combinational-read memory. LS has priority; IF is forced through after
// STARVE_LIMIT consecutive losses. Each port owns a single response slot.
// Optional build macro MEM_ARB_ALIGN_CHECK_EN: misaligned requests are
// consumed without touching memory and answered with err=1.

// One response slot: loads on grant, clears on handshake, reload wins.
module mem_arb_slot (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        load_err,
  input  logic        rsp_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);
  // slot register: grant reload takes precedence over drain
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else if (load) begin
      rsp_valid <= 1'b1;
      rsp_data  <= load_data;
      rsp_err   <= load_err;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end
  end
endmodule

module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  output logic        if_rsp_err,
  input  logic        if_rsp_ready,
  input  logic        ls_req_valid,
  input  logic [31:0] ls_req_addr,
  input  logic        ls_req_write,
  input  logic [31:0] ls_req_wdata,
  output logic        ls_req_ready,
  output logic        ls_rsp_valid,
  output logic [31:0] ls_rsp_data,
  output logic        ls_rsp_err,
  input  logic        ls_rsp_ready,
  output logic [31:0] mem_address,
  output logic        mem_read_write,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);
  localparam int          NUM_PORTS = 2;
  localparam int          P_IF      = 0;
  localparam int          P_LS      = 1;
  localparam logic [31:0] IDLE_ADDR = 32'h0100_0000;
  localparam logic [3:0]  LIMIT     = 4'(STARVE_LIMIT);

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
  } req_t;

  req_t [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS-1:0]        rsp_ready, rsp_valid, rsp_err;
  logic [NUM_PORTS-1:0][31:0]  rsp_data, load_data;
  logic [NUM_PORTS-1:0]        elig, gnt, mis;
  logic [3:0]                  starve_cnt;
  logic                        if_force;

  assign req[P_IF] = '{valid: if_req_valid, addr: if_req_addr, write: 1'b0, wdata: 32'h0};
  assign req[P_LS] = '{valid: ls_req_valid, addr: ls_req_addr, write: ls_req_write, wdata: ls_req_wdata};
  assign rsp_ready = {ls_rsp_ready, if_rsp_ready};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    // slot is free when empty or being drained this cycle
    assign elig[p] = req[p].valid && (!rsp_valid[p] || rsp_ready[p]);
`ifdef MEM_ARB_ALIGN_CHECK_EN
    assign mis[p] = (req[p].addr[1:0] != 2'b00);
`else
    assign mis[p] = 1'b0;
`endif
    // stores and rejected accesses return zero data
    assign load_data[p] = (mis[p] || req[p].write) ? 32'h0 : mem_data_out;

    mem_arb_slot u_slot (
      .clock     (clock),
      .reset     (reset),
      .load      (gnt[p]),
      .load_data (load_data[p]),
      .load_err  (mis[p]),
      .rsp_ready (rsp_ready[p]),
      .rsp_valid (rsp_valid[p]),
      .rsp_data  (rsp_data[p]),
      .rsp_err   (rsp_err[p])
    );
  end

  // grant: LS first unless IF has hit its starvation limit; nothing in reset
  always_comb begin
    gnt      = '0;
    if_force = elig[P_IF] && (starve_cnt == LIMIT);
    if (!reset) begin
      if (elig[P_LS] && !if_force) gnt[P_LS] = 1'b1;
      else if (elig[P_IF])         gnt[P_IF] = 1'b1;
    end
  end

  // memory port drive; misaligned grants look like idle cycles
  always_comb begin
    mem_address    = IDLE_ADDR;
    mem_read_write = 1'b0;
    mem_data_in    = 32'h0;
    if (gnt[P_LS] && !mis[P_LS]) begin
      mem_address    = req[P_LS].addr;
      mem_read_write = req[P_LS].write;
      mem_data_in    = req[P_LS].write ? req[P_LS].wdata : 32'h0;
    end else if (gnt[P_IF] && !mis[P_IF]) begin
      mem_address    = req[P_IF].addr;
    end
  end

  // starvation counter: counts IF losses to LS, saturates at the limit
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                               starve_cnt <= '0;
    else if (!if_req_valid || gnt[P_IF])                     starve_cnt <= '0;
    else if (elig[P_IF] && gnt[P_LS] && (starve_cnt < LIMIT)) starve_cnt <= starve_cnt + 4'd1;
  end

  assign if_req_ready = gnt[P_IF];
  assign ls_req_ready = gnt[P_LS];
  assign if_rsp_valid = rsp_valid[P_IF];
  assign if_rsp_data  = rsp_data[P_IF];
  assign if_rsp_err   = rsp_err[P_IF];
  assign ls_rsp_valid = rsp_valid[P_LS];
  assign ls_rsp_data  = rsp_data[P_LS];
  assign ls_rsp_err   = rsp_err[P_LS];
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and response sequencer for the single-port, byte-addressed, combinational-read instruction/data memory. It sits between the fetch stage (IF) and the load/store unit (LS) on one side and the shared memory port on the other. It grants at most one access per cycle, drives the memory's address, read_write and data_in, and captures the word into a per-requester response register. Responses are returned with a valid/ready handshake.

## Interface
- STARVE_LIMIT, default 4: consecutive cycles IF may lose arbitration before it is forced to win (1..15).
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req_valid  in  1  fetch request.
- if_req_addr  in  32  fetch byte address.
- if_req_ready  out  1  fetch request granted this cycle.
- if_rsp_valid  out  1  fetch response held.
- if_rsp_data  out  32  fetched word.
- if_rsp_err  out  1  fetch error flag.
- if_rsp_ready  in  1  fetch consumer accepts the response.
- ls_req_valid  in  1  load/store request.
- ls_req_addr  in  32  load/store byte address.
- ls_req_write  in  1  1 = store, 0 = load.
- ls_req_wdata  in  32  store data.
- ls_req_ready  out  1  load/store request granted this cycle.
- ls_rsp_valid, ls_rsp_data[31:0], ls_rsp_err, ls_rsp_ready: same semantics as the IF response signals.
- mem_address  out  32  to memory address.
- mem_read_write  out  1  to memory read_write (1 = write).
- mem_data_in  out  32  to memory data_in.
- mem_data_out  in  32  from memory data_out, combinational.

## Operation
- Each requester has one response slot (valid, data, err).
- A requester is eligible when req_valid=1 and its slot is free: slot empty, or rsp_valid and rsp_ready both 1 this cycle.
- Priority: LS over IF. Exception: IF wins when IF is eligible and starve_cnt == STARVE_LIMIT.
- starve_cnt (4 bits):
  - +1, saturating at STARVE_LIMIT, in each cycle IF is eligible and LS is granted.
  - Cleared when IF is granted, and in any cycle if_req_valid=0.
- Grant cycle for X:
  - x_req_ready=1.
  - mem_address = x_req_addr.
  - For a granted LS store: mem_read_write=1 and mem_data_in=ls_req_wdata.
  - Otherwise mem_read_write=0 and mem_data_in=0.
- Idle cycle: mem_address=32'h0100_0000, mem_read_write=0, mem_data_in=0.
- mem_read_write is never 1 outside an LS store grant cycle. The memory writes while the level is high.
- Slot load on the clock edge after grant:
  - Reads: data = mem_data_out sampled in the grant cycle.
  - Stores: data = 0.
  - err = 0.
- Slot clears when rsp_valid and rsp_ready are both 1, unless reloaded in the same cycle.
- Requesters hold addr, write and wdata stable while valid=1 and ready=0.
- Both ready outputs are never 1 in the same cycle.

## Timing
- Request-to-response latency: 1 cycle. Grant in cycle N, rsp_valid=1 from cycle N+1.
- Peak throughput is 1 access per cycle across both ports, and back-to-back on one port when its response is drained every cycle.
- req_ready and all mem_* outputs are combinational from the request inputs and the slot/counter registers. There is no combinational path from mem_data_out to any output.
- Response signals are registered.
- Reset values: if_rsp_valid=0, ls_rsp_valid=0, rsp_data=0, rsp_err=0, starve_cnt=0.
- While reset=1: both req_ready=0, mem_read_write=0, mem_address=32'h0100_0000, mem_data_in=0.
- Reset mid-access: a store whose grant coincides with reset assertion is not issued. Slots are discarded.
- Simultaneous slot drain and new grant on one port: the new response replaces the old one, and rsp_valid stays 1.

## Configuration
- MEM_ARB_ALIGN_CHECK_EN defined:
  - A granted request with addr[1:0] != 0 is consumed (req_ready=1) but not issued: mem_read_write=0, mem_address=32'h0100_0000.
  - Its slot loads err=1, data=0.
- MEM_ARB_ALIGN_CHECK_EN undefined:
  - No alignment check; the address passes through unchanged.
  - err is constant 0.

## Test plan
- After reset, IF reads 0x0100_0000 holding 0x00500093 with if_rsp_ready=1 -> if_req_ready=1 in cycle 0; cycle 1 if_rsp_valid=1, if_rsp_data=0x00500093, err=0.
- LS stores 0xDEADBEEF to 0x0100_0010, then loads the same address -> mem_read_write=1 only in the store grant cycle; ls_rsp_data=0 for the store, then 0xDEADBEEF for the load.
- Both request continuously with STARVE_LIMIT=4 and both rsp_ready=1 -> LS granted 4 cycles, IF granted in the 5th, repeating; never both ready in one cycle.
- IF response held with if_rsp_ready=0 for 3 cycles while if_req_valid=1 -> if_req_ready=0 and the response stays stable; when if_rsp_ready=1, the new request is granted in the same cycle.
- Reset asserted while an LS store is pending -> mem_read_write falls to 0 immediately, rsp_valid=0; after release the memory word is unchanged.
- With MEM_ARB_ALIGN_CHECK_EN, an LS load at 0x0100_0002 -> ls_rsp_err=1, data=0, no memory write; without the macro, err=0 and the data is the memory contents.
